// File: rtl/mmio_router.sv
// MMIO router: decodes CPU loads/stores onto RAM, a keyboard scancode FIFO and
// a 7-seg register; read data is registered with a one-cycle valid.
module mmio_router #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 64,
    parameter int                KB_W     = 8,
    parameter int                KB_DEPTH = 8,
    parameter int                SEG_W    = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] RAM_LEN  = 32'h0800_0000,
    parameter logic [ADDR_W-1:0] KB_BASE  = 32'ha000_0060,
    parameter logic [ADDR_W-1:0] SEG_BASE = 32'ha000_0100,
    parameter logic [ADDR_W-1:0] PERI_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ren,
    input  logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        wdt_op,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              bus_err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_wdt_op,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              kb_valid,
    input  logic [KB_W-1:0]   kb_data,
    output logic              kb_ready,
    output logic [SEG_W-1:0]  seg_wdata
);
    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [KB_W-1:0]   kb_mem_q [KB_DEPTH];
    logic [KB_W-1:0]   kb_mem_d [KB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] rd_ram_off, rd_kb_off, rd_seg_off;
    logic [ADDR_W-1:0] wr_ram_off, wr_kb_off, wr_seg_off;
    logic rd_ram_hit, rd_kb_hit, rd_seg_hit, rd_hit;
    logic wr_ram_hit, wr_kb_hit, wr_seg_hit, wr_hit;
    logic push, pop, kb_empty;
    int   seg_lim;

    // Offset-based compare stays correct even when base+len would overflow ADDR_W.
    always_comb begin
        rd_ram_off = mem_raddr - RAM_BASE;
        rd_kb_off  = mem_raddr - KB_BASE;
        rd_seg_off = mem_raddr - SEG_BASE;
        wr_ram_off = mem_waddr - RAM_BASE;
        wr_kb_off  = mem_waddr - KB_BASE;
        wr_seg_off = mem_waddr - SEG_BASE;
        rd_ram_hit = (mem_raddr >= RAM_BASE) && (rd_ram_off < RAM_LEN);
        rd_kb_hit  = (mem_raddr >= KB_BASE)  && (rd_kb_off  < PERI_LEN);
        rd_seg_hit = (mem_raddr >= SEG_BASE) && (rd_seg_off < PERI_LEN);
        wr_ram_hit = (mem_waddr >= RAM_BASE) && (wr_ram_off < RAM_LEN);
        wr_kb_hit  = (mem_waddr >= KB_BASE)  && (wr_kb_off  < PERI_LEN);
        wr_seg_hit = (mem_waddr >= SEG_BASE) && (wr_seg_off < PERI_LEN);
        rd_hit     = rd_ram_hit || rd_kb_hit || rd_seg_hit;
        wr_hit     = wr_ram_hit || wr_kb_hit || wr_seg_hit;
    end

    assign ram_ren    = mem_ren & rd_ram_hit;
    assign ram_wen    = mem_wen & wr_ram_hit;
    assign ram_raddr  = mem_raddr;
    assign ram_waddr  = mem_waddr;
    assign ram_wdata  = mem_wdata;
    assign ram_wdt_op = wdt_op;

    assign kb_empty = (count_q == '0);
    assign kb_ready = (count_q != CNT_W'(KB_DEPTH));
    assign push     = kb_valid & kb_ready;
    assign pop      = mem_ren & rd_kb_hit & ~rd_kb_off[2] & ~kb_empty;

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = mem_ren;
        err_d    = (mem_ren & ~rd_hit) | (mem_wen & ~wr_hit);
        if (mem_ren) begin
            rdata_d = '0;
            if (rd_ram_hit)
                rdata_d = ram_rdata;
            else if (rd_kb_hit && rd_kb_off[2])
                rdata_d = DATA_W'(count_q);
            else if (rd_kb_hit && !kb_empty)
                rdata_d = DATA_W'(kb_mem_q[head_q]);
            else if (rd_seg_hit)
                rdata_d = DATA_W'(seg_q);
        end
    end

    // Byte/half writes touch only the low bits; word and dword fill the register.
    always_comb begin
        seg_d   = seg_q;
        seg_lim = SEG_W;
        if (wdt_op[0])
            seg_lim = 8;
        else if (wdt_op[1])
            seg_lim = 16;
        if (mem_wen && wr_seg_hit && (wdt_op != 4'b0000)) begin
            for (int i = 0; i < SEG_W; i++)
                if (i < seg_lim) seg_d[i] = mem_wdata[i];
        end
    end

    always_comb begin
        kb_mem_d = kb_mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (push) begin
            kb_mem_d[tail_q] = kb_data;
            tail_d           = tail_q + 1'b1;
        end
        if (pop)
            head_d = head_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            seg_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            seg_q    <= seg_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        kb_mem_q <= kb_mem_d;
    end

    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;
    assign bus_err    = err_q;
    assign seg_wdata  = seg_q;
endmodule

// File: tb/tb_mmio_router.sv
// Directed self-checking bench for mmio_router with hand-computed expectations.
module tb_mmio_router;
   localparam logic [31:0] KB  = 32'ha000_0060;
   localparam logic [31:0] SEG = 32'ha000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ren, mem_wen, kb_valid;
   logic [31:0] mem_raddr, mem_waddr;
   logic [63:0] mem_wdata, ram_rdata;
   logic [3:0]  wdt_op;
   logic [7:0]  kb_data;
   logic [63:0] mem_rdata, ram_wdata;
   logic        mem_rvalid, bus_err, ram_ren, ram_wen, kb_ready;
   logic [31:0] ram_raddr, ram_waddr, seg_wdata;
   logic [3:0]  ram_wdt_op;

   int total = 0;
   int bad   = 0;

   mmio_router dut (
      .clk(clk), .rst(rst),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .wdt_op(wdt_op),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .bus_err(bus_err),
      .ram_ren(ram_ren), .ram_wen(ram_wen),
      .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_wdt_op(ram_wdt_op), .ram_rdata(ram_rdata),
      .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
      .seg_wdata(seg_wdata)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it, away from the sampling edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic readAt(input logic [31:0] addr);
      mem_ren   = 1'b1;
      mem_raddr = addr;
      applyStimulus();
      mem_ren   = 1'b0;
   endtask

   task automatic pushCode(input logic [7:0] code);
      kb_valid = 1'b1;
      kb_data  = code;
      applyStimulus();
      kb_valid = 1'b0;
   endtask

   task automatic writeSeg(input logic [63:0] data, input logic [3:0] op);
      mem_wen   = 1'b1;
      mem_waddr = SEG;
      mem_wdata = data;
      wdt_op    = op;
      applyStimulus();
      mem_wen   = 1'b0;
   endtask

   // Directed scenario sequence; each block mirrors one behaviour of the router.
   initial begin
      rst = 1'b1; mem_ren = 0; mem_wen = 0; kb_valid = 0;
      mem_raddr = 0; mem_waddr = 0; mem_wdata = 0; wdt_op = 4'b0100;
      ram_rdata = 0; kb_data = 0;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkOutput("rst_rdata",  mem_rdata,  64'h0);
      checkOutput("rst_rvalid", mem_rvalid, 64'h0);
      checkOutput("rst_err",    bus_err,    64'h0);
      checkOutput("rst_seg",    seg_wdata,  64'h0);
      checkOutput("rst_ready",  kb_ready,   64'h1);

      readAt(SEG);
      checkOutput("seg_rd_valid", mem_rvalid, 64'h1);
      checkOutput("seg_rd_data",  mem_rdata,  64'h0);
      checkOutput("seg_rd_err",   bus_err,    64'h0);
      applyStimulus();
      checkOutput("idle_valid", mem_rvalid, 64'h0);

      pushCode(8'h1C);
      pushCode(8'h32);
      readAt(KB + 4);
      checkOutput("kb_status2", mem_rdata, 64'h2);
      readAt(KB);
      checkOutput("kb_pop1", mem_rdata, 64'h1C);
      readAt(KB);
      checkOutput("kb_pop2", mem_rdata, 64'h32);
      readAt(KB);
      checkOutput("kb_empty_rd", mem_rdata, 64'h0);
      readAt(KB + 4);
      checkOutput("kb_status0", mem_rdata, 64'h0);

      for (int i = 0; i < 8; i++) pushCode(8'h10 + 8'(i));
      checkOutput("kb_full_ready", kb_ready, 64'h0);
      pushCode(8'hFF);
      readAt(KB + 4);
      checkOutput("kb_status8", mem_rdata, 64'h8);
      readAt(KB);
      checkOutput("kb_pop_full", mem_rdata, 64'h10);
      checkOutput("kb_ready7", kb_ready, 64'h1);
      kb_valid = 1'b1; kb_data = 8'h77;
      readAt(KB);
      kb_valid = 1'b0;
      checkOutput("kb_pushpop_data", mem_rdata, 64'h11);
      readAt(KB + 4);
      checkOutput("kb_pushpop_cnt", mem_rdata, 64'h7);
      pushCode(8'h78);
      readAt(KB + 4);
      checkOutput("kb_refill_cnt", mem_rdata, 64'h8);
      for (int i = 0; i < 6; i++) begin
         readAt(KB);
         checkOutput("kb_drain", mem_rdata, 64'h12 + 64'(i));
      end
      readAt(KB);
      checkOutput("kb_drain_77", mem_rdata, 64'h77);
      readAt(KB);
      checkOutput("kb_drain_78", mem_rdata, 64'h78);

      writeSeg(64'h1234_5678, 4'b0100);
      checkOutput("seg_word", seg_wdata, 64'h1234_5678);
      writeSeg(64'hAB, 4'b0001);
      checkOutput("seg_byte", seg_wdata, 64'h1234_56AB);
      writeSeg(64'h9999_CDEF, 4'b0010);
      checkOutput("seg_half", seg_wdata, 64'h1234_CDEF);
      mem_ren = 1'b1; mem_raddr = SEG;
      writeSeg(64'hFFFF_FFFF_0BAD_F00D, 4'b1000);
      mem_ren = 1'b0;
      checkOutput("seg_rw_old", mem_rdata, 64'h1234_CDEF);
      checkOutput("seg_dword",  seg_wdata, 64'h0BAD_F00D);

      mem_wen = 1'b1; mem_waddr = KB; mem_wdata = 64'h55;
      applyStimulus();
      mem_wen = 1'b0;
      checkOutput("kb_wr_noerr", bus_err, 64'h0);
      readAt(KB + 4);
      checkOutput("kb_wr_nopush", mem_rdata, 64'h0);

      mem_ren = 1'b1; mem_raddr = 32'h8000_0010; ram_rdata = 64'hDEAD_BEEF;
      #1;
      checkOutput("ram_ren", ram_ren, 64'h1);
      checkOutput("ram_raddr", ram_raddr, 64'h8000_0010);
      applyStimulus();
      mem_ren = 1'b0; ram_rdata = 64'h0;
      checkOutput("ram_rdata",  mem_rdata,  64'hDEAD_BEEF);
      checkOutput("ram_rvalid", mem_rvalid, 64'h1);
      mem_wen = 1'b1; mem_waddr = 32'h87FF_FFF8; #1;
      checkOutput("ram_wen_top", ram_wen, 64'h1);
      mem_wen = 1'b0;
      mem_raddr = 32'h8800_0000; mem_ren = 1'b1; #1;
      checkOutput("ram_ren_past", ram_ren, 64'h0);
      applyStimulus();
      mem_ren = 1'b0;
      checkOutput("ram_past_err", bus_err, 64'h1);

      readAt(32'h0000_0000);
      checkOutput("unmap_err",   bus_err,    64'h1);
      checkOutput("unmap_rdata", mem_rdata,  64'h0);
      checkOutput("unmap_valid", mem_rvalid, 64'h1);
      applyStimulus();
      checkOutput("err_pulse", bus_err, 64'h0);

      pushCode(8'h01); pushCode(8'h02); pushCode(8'h03);
      rst = 1'b1; mem_ren = 1'b1; mem_raddr = SEG;
      applyStimulus();
      rst = 1'b0; mem_ren = 1'b0;
      checkOutput("rst_cancel_valid", mem_rvalid, 64'h0);
      checkOutput("rst_seg_clear",    seg_wdata,  64'h0);
      readAt(KB + 4);
      checkOutput("rst_kb_status", mem_rdata, 64'h0);
      checkOutput("rst_kb_ready",  kb_ready,  64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
